// File: rtl/mandelbrot_iterator_param.sv
// Escape-time iterator for one complex point, Mandelbrot or Julia start,
// one z <- z^2 + c step per clock with a valid/ready result handshake.
//   state  | meaning
//   S_IDLE | waiting for an operand set
//   S_CALC | iterating z
//   S_DONE | result held until out_ready
module mandelbrot_iterator_param #(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     julia_mode,
  input  logic signed [WIDTH-1:0]  c_re,
  input  logic signed [WIDTH-1:0]  c_im,
  input  logic signed [WIDTH-1:0]  z0_re,
  input  logic signed [WIDTH-1:0]  z0_im,
  input  logic [ITER_W-1:0]        max_iter,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ITER_W-1:0]        out_iter,
  output logic                     out_escaped,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int PW = 2 * WIDTH;
  localparam int MW = PW + 1;
  localparam int SW = WIDTH + 2;
  localparam logic signed [MW-1:0] FOUR = {{(MW-FRAC-3){1'b0}}, 3'b100, {FRAC{1'b0}}};

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
  logic [ITER_W-1:0] n_q, n_d, max_q, max_d, iter_q, iter_d;
  logic esc_q, esc_d;
  logic accept;

  logic signed [PW-1:0] rr_full, ii_full, ri_full, rr_s, ii_s;
  logic signed [SW-2:0] ri_s;
  logic signed [MW-1:0] mag;
  logic signed [SW-1:0] re_sum, im_sum;
  logic escape;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (&v[SW-1:WIDTH-1] || ~|v[SW-1:WIDTH-1])
      return v[WIDTH-1:0];
    else if (v[SW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // The escape test is done at full product width so a saturated z can never
  // wrap back under 4.0; the update sums only matter when |z|^2 <= 4, where
  // WIDTH+2 bits cannot overflow.
  always_comb begin
    rr_full = zr_q * zr_q;
    ii_full = zi_q * zi_q;
    ri_full = zr_q * zi_q;
    rr_s    = rr_full >>> FRAC;
    ii_s    = ii_full >>> FRAC;
    ri_s    = (SW-1)'(ri_full >>> FRAC);
    mag     = {rr_s[PW-1], rr_s} + {ii_s[PW-1], ii_s};
    escape  = mag > FOUR;
    re_sum  = rr_s[SW-1:0] - ii_s[SW-1:0] + {{2{cr_q[WIDTH-1]}}, cr_q};
    im_sum  = {ri_s, 1'b0} + {{2{ci_q[WIDTH-1]}}, ci_q};
  end

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_CALC);
  assign out_iter    = iter_q;
  assign out_escaped = esc_q;

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    n_d     = n_q;
    max_d   = max_q;
    iter_d  = iter_q;
    esc_d   = esc_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: accept = in_valid && !abort;
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (escape) begin
          state_d = S_DONE;
          iter_d  = n_q;
          esc_d   = 1'b1;
        end else if (n_q == max_q) begin
          state_d = S_DONE;
          iter_d  = n_q;
          esc_d   = 1'b0;
        end else begin
          zr_d = sat(re_sum);
          zi_d = sat(im_sum);
          n_d  = n_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          accept  = in_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_CALC;
      cr_d    = c_re;
      ci_d    = c_im;
      max_d   = max_iter;
      zr_d    = julia_mode ? z0_re : '0;
      zi_d    = julia_mode ? z0_im : '0;
      n_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      n_q     <= '0;
      max_q   <= '0;
      iter_q  <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      n_q     <= n_d;
      max_q   <= max_d;
      iter_q  <= iter_d;
      esc_q   <= esc_d;
    end
  end

endmodule

// File: tb/tb_mandelbrot_iterator_param.sv
// Directed and randomized bench for mandelbrot_iterator_param against an
// arithmetic escape-time model.
module tb_mandelbrot_iterator_param;
  localparam int W = 27;
  localparam int F = 23;
  localparam int IW = 10;
  localparam longint ONE = 64'sd1 << F;
  localparam longint FOUR = 64'sd4 << F;
  localparam longint SMAX = (64'sd1 << (W-1)) - 1;
  localparam longint SMIN = -(64'sd1 << (W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, julia_mode = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic signed [W-1:0] c_re = '0, c_im = '0, z0_re = '0, z0_im = '0;
  logic [IW-1:0] max_iter = '0;
  logic in_ready, out_valid, out_escaped, busy;
  logic [IW-1:0] out_iter;

  int checks = 0;
  int errors = 0;

  mandelbrot_iterator_param #(.WIDTH(W), .FRAC(F), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .julia_mode(julia_mode), .c_re(c_re), .c_im(c_im), .z0_re(z0_re), .z0_im(z0_im),
    .max_iter(max_iter), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_iter(out_iter), .out_escaped(out_escaped), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint satw(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Straight escape-time recurrence on integers scaled by 2^F.
  function automatic void model(input longint cr, input longint ci, input longint zr0,
                                input longint zi0, input int mx, output int it, output bit esc);
    longint zr, zi, rr, ii, ri;
    zr = zr0;
    zi = zi0;
    it = mx;
    esc = 1'b0;
    for (int n = 0; n <= mx; n++) begin
      rr = (zr * zr) >>> F;
      ii = (zi * zi) >>> F;
      ri = (zr * zi) >>> F;
      if (rr + ii > FOUR) begin
        it = n; esc = 1'b1; return;
      end
      if (n == mx) begin
        it = n; esc = 1'b0; return;
      end
      zr = satw(rr - ii + cr);
      zi = satw(2 * ri + ci);
    end
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic start(input longint cr, input longint ci, input bit jm,
                       input longint zr0, input longint zi0, input int mx);
    c_re = W'(cr); c_im = W'(ci); julia_mode = jm;
    z0_re = W'(zr0); z0_im = W'(zi0); max_iter = IW'(mx);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 1100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input longint cr, input longint ci,
                               input bit jm, input longint zr0, input longint zi0,
                               input int mx, input int lat);
    int it; bit esc;
    model(cr, ci, jm ? zr0 : 0, jm ? zi0 : 0, mx, it, esc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_iter"}, 32'(out_iter), 32'(it));
    check({tag, "_esc"}, 32'(out_escaped), 32'(esc));
    check({tag, "_lat"}, 32'(lat), 32'(it + 1));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input longint cr, input longint ci, input bit jm,
                     input longint zr0, input longint zi0, input int mx);
    int lat;
    start(cr, ci, jm, zr0, zi0, mx);
    wait_result(lat);
    expect_result(tag, cr, ci, jm, zr0, zi0, mx, lat);
    consume();
  endtask

  initial begin
    int lat, hold_it;
    bit hold_esc;
    longint rc_re, rc_im, rz_re, rz_im;
    int rmx;
    bit rjm, junk;

    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_iter", 32'(out_iter), 32'd0);
    check("rst_esc", 32'(out_escaped), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd1);

    run("c0_cap1000", 0, 0, 0, 0, 0, 1000);
    run("c1", ONE, 0, 0, 0, 0, 100);
    run("c2p5", 5 * ONE / 2, 0, 0, 0, 0, 100);
    run("ci1", 0, ONE, 0, 0, 0, 50);
    run("max0", 0, 0, 0, 0, 0, 0);
    run("julia3", 0, 0, 1, 3 * ONE, 0, 20);
    run("julia_half", 0, 0, 1, ONE / 2, 0, 20);
    run("julia_edge", 0, 0, 1, 2 * ONE, 0, 5);

    // Result held in DONE, then back-to-back accept.
    start(ONE, 0, 0, 0, 0, 100);
    wait_result(lat);
    model(ONE, 0, 0, 0, 100, hold_it, hold_esc);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_iter", 32'(out_iter), 32'(hold_it));
      check("hold_esc", 32'(out_escaped), 32'(hold_esc));
      check("hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    c_re = W'(5 * ONE / 2); c_im = '0; julia_mode = 1'b0; max_iter = IW'(100);
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_valid_drop", 32'(out_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_result(lat);
    expect_result("b2b", 5 * ONE / 2, 0, 0, 0, 0, 100, lat);
    consume();

    // Abort at n = 5.
    start(0, 0, 0, 0, 0, 100);
    repeat (5) begin @(posedge clk); #1; end
    abort = 1'b1;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("abort_no_valid", 32'(out_valid), 32'd0);

    // Abort wins over in_valid in IDLE.
    c_re = '0; c_im = '0; max_iter = IW'(10);
    in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_noaccept", 32'(busy), 32'd0);

    // Asynchronous reset mid-CALC.
    start(0, 0, 0, 0, 0, 100);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_iter", 32'(out_iter), 32'd0);
    check("arst_esc", 32'(out_escaped), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    check("arst_ready", 32'(in_ready), 32'd1);

    // Random points; Mandelbrot mode gets junk z0, and some runs keep
    // in_valid high with other operands while busy.
    for (int k = 0; k < 40; k++) begin
      rc_re = longint'($urandom_range(0, 41943040)) - 20971520;
      rc_im = longint'($urandom_range(0, 41943040)) - 20971520;
      rz_re = longint'($urandom_range(0, 50331648)) - 25165824;
      rz_im = longint'($urandom_range(0, 50331648)) - 25165824;
      rjm = 1'($urandom_range(0, 1));
      junk = 1'($urandom_range(0, 1));
      rmx = int'($urandom_range(0, 60));
      start(rc_re, rc_im, rjm, rz_re, rz_im, rmx);
      if (junk) begin
        c_re = W'($urandom); c_im = W'($urandom); z0_re = W'($urandom);
        julia_mode = ~rjm; max_iter = IW'($urandom);
        in_valid = 1'b1;
      end
      wait_result(lat);
      in_valid = 1'b0;
      expect_result("rand", rc_re, rc_im, rjm, rz_re, rz_im, rmx, lat);
      consume();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
